// File: rtl/dsi_video_scheduler.sv
// dsi_video_scheduler: walks a raster frame and issues the DSI video-mode packet sequence per line
// (VSS/VSE/HSS short, blanking long, RGB888 long) to the packet assembler, paced by a line timer.
// Ports: clk_i/rst_i; enable_i; cfg_h_*/cfg_v_* timing; pix_i/pix_valid_i/pix_ack_o pixel source;
// frame_start_o, err_underrun_o, err_late_o status; p_* assembler request interface with p_dreq_i.
module dsi_video_scheduler #(
    parameter int g_hcnt_bits = 16,
    parameter int g_vcnt_bits = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [g_hcnt_bits-1:0] cfg_h_total_i,
    input  logic [g_hcnt_bits-1:0] cfg_h_active_i,
    input  logic [g_hcnt_bits-1:0] cfg_h_blank_i,
    input  logic [g_vcnt_bits-1:0] cfg_v_sync_i,
    input  logic [g_vcnt_bits-1:0] cfg_v_back_i,
    input  logic [g_vcnt_bits-1:0] cfg_v_active_i,
    input  logic [g_vcnt_bits-1:0] cfg_v_front_i,
    input  logic [23:0]            pix_i,
    input  logic                   pix_valid_i,
    output logic                   pix_ack_o,
    output logic                   frame_start_o,
    output logic                   err_underrun_o,
    output logic                   err_late_o,
    output logic                   p_req_o,
    output logic                   p_islong_o,
    output logic [5:0]             p_type_o,
    output logic [15:0]            p_wcount_o,
    output logic [15:0]            p_command_o,
    output logic [23:0]            p_payload_o,
    output logic                   p_last_o,
    input  logic                   p_dreq_i
);
    localparam int HB = g_hcnt_bits;
    localparam int VB = g_vcnt_bits;
    localparam int VW = g_vcnt_bits + 2;
    localparam logic [HB-1:0] H_ONE = 1;
    localparam logic [VB-1:0] V_ONE = 1;
    localparam logic [VW-1:0] VW_ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_SHORT, S_BLANK, S_RGB, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [HB-1:0]   h_cnt_q, h_cnt_d;
    logic [VB-1:0]   v_cnt_q, v_cnt_d;
    logic            hdr_q, hdr_d;
    logic [HB-1:0]   w_cnt_q, w_cnt_d;
    logic            err_underrun_q, err_underrun_d;
    logic            err_late_q, err_late_d;
    logic            cfg_load;
    logic [HB-1:0]   h_total_q, h_active_q, h_blank_q;
    logic [VB-1:0]   v_sync_q, v_back_q, v_active_q, v_front_q;

    // Line classification from the frame's latched vertical timing
    logic [VW-1:0] v_ext, act_lo, act_hi, v_last;
    logic          is_vss, is_vse, is_active, v_wrap;
    assign v_ext     = {2'b00, v_cnt_q};
    assign act_lo    = {2'b00, v_sync_q} + {2'b00, v_back_q};
    assign act_hi    = act_lo + {2'b00, v_active_q};
    assign v_last    = act_hi + {2'b00, v_front_q} - VW_ONE;
    assign is_vss    = (v_cnt_q == '0);
    assign is_vse    = (v_cnt_q == v_sync_q);
    assign is_active = !is_vss && !is_vse && (v_ext >= act_lo) && (v_ext < act_hi);
    assign v_wrap    = (v_ext == v_last);

    // Long packet progress: hdr_q marks the header as accepted, w_cnt_q counts payload words
    logic [HB-1:0] n_words;
    logic          long_st, word_last, seq_done, at_end, line_end;
    assign n_words   = (state_q == S_RGB) ? h_active_q : h_blank_q;
    assign long_st   = (state_q == S_BLANK) || (state_q == S_RGB);
    assign word_last = hdr_q && (w_cnt_q == n_words - H_ONE);
    assign seq_done  = p_dreq_i && (((state_q == S_SHORT) && !is_active) ||
                                    ((state_q == S_RGB) && word_last));
    assign at_end    = (h_cnt_q == h_total_q - H_ONE);
    // A line ends at the timer's last count once the sequence is done; a late line
    // keeps the timer parked at that count until its final word goes out.
    assign line_end  = at_end && ((state_q == S_WAIT) || seq_done);

    logic [HB+1:0] wc_blank, wc_rgb;
    assign wc_blank = {h_blank_q, 1'b0} + {2'b00, h_blank_q};
    assign wc_rgb   = {h_active_q, 1'b0} + {2'b00, h_active_q};

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable_i) state_d = S_SHORT;
            S_SHORT: if (p_dreq_i) begin
                if (is_active)     state_d = (h_blank_q != '0) ? S_BLANK : S_RGB;
                else if (line_end) state_d = enable_i ? S_SHORT : S_IDLE;
                else               state_d = S_WAIT;
            end
            S_BLANK: if (p_dreq_i && word_last) state_d = S_RGB;
            S_RGB:   if (seq_done) state_d = line_end ? (enable_i ? S_SHORT : S_IDLE) : S_WAIT;
            S_WAIT:  if (line_end) state_d = enable_i ? S_SHORT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        p_req_o       = 1'b0;
        p_islong_o    = 1'b0;
        p_type_o      = 6'h00;
        p_wcount_o    = 16'h0000;
        p_payload_o   = 24'h000000;
        p_last_o      = 1'b0;
        pix_ack_o     = 1'b0;
        frame_start_o = 1'b0;
        case (state_q)
            S_SHORT: begin
                p_req_o       = 1'b1;
                p_type_o      = is_vss ? 6'h01 : (is_vse ? 6'h11 : 6'h21);
                p_last_o      = !is_active;
                frame_start_o = is_vss && (h_cnt_q == '0);
            end
            S_BLANK: begin
                p_req_o    = 1'b1;
                p_islong_o = 1'b1;
                p_type_o   = 6'h19;
                p_wcount_o = 16'(wc_blank);
            end
            S_RGB: begin
                p_req_o     = 1'b1;
                p_islong_o  = 1'b1;
                p_type_o    = 6'h3E;
                p_wcount_o  = 16'(wc_rgb);
                p_last_o    = 1'b1;
                p_payload_o = pix_valid_i ? pix_i : 24'h000000;
                pix_ack_o   = hdr_q && p_dreq_i;
            end
            default: ;
        endcase
    end
    assign p_command_o    = 16'h0000;
    assign err_underrun_o = err_underrun_q;
    assign err_late_o     = err_late_q;

    // Datapath next-state: timer, line counter, packet progress, sticky errors
    always_comb begin
        h_cnt_d        = h_cnt_q;
        v_cnt_d        = v_cnt_q;
        hdr_d          = hdr_q;
        w_cnt_d        = w_cnt_q;
        err_underrun_d = err_underrun_q;
        err_late_d     = err_late_q;
        cfg_load       = 1'b0;
        if (state_q == S_IDLE) begin
            h_cnt_d  = '0;
            v_cnt_d  = '0;
            cfg_load = enable_i;
        end else if (line_end) begin
            h_cnt_d  = '0;
            v_cnt_d  = (!enable_i || v_wrap) ? '0 : v_cnt_q + V_ONE;
            cfg_load = enable_i && v_wrap;
        end else if (at_end) begin
            err_late_d = 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + H_ONE;
        end
        if (long_st && p_dreq_i) begin
            if (!hdr_q) begin
                hdr_d = 1'b1;
            end else if (word_last) begin
                hdr_d   = 1'b0;
                w_cnt_d = '0;
            end else begin
                w_cnt_d = w_cnt_q + H_ONE;
            end
        end
        if ((state_q == S_RGB) && hdr_q && p_dreq_i && !pix_valid_i) err_underrun_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            hdr_q          <= 1'b0;
            w_cnt_q        <= '0;
            err_underrun_q <= 1'b0;
            err_late_q     <= 1'b0;
            h_total_q      <= '0;
            h_active_q     <= '0;
            h_blank_q      <= '0;
            v_sync_q       <= '0;
            v_back_q       <= '0;
            v_active_q     <= '0;
            v_front_q      <= '0;
        end else begin
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            hdr_q          <= hdr_d;
            w_cnt_q        <= w_cnt_d;
            err_underrun_q <= err_underrun_d;
            err_late_q     <= err_late_d;
            if (cfg_load) begin
                h_total_q  <= cfg_h_total_i;
                h_active_q <= cfg_h_active_i;
                h_blank_q  <= cfg_h_blank_i;
                v_sync_q   <= cfg_v_sync_i;
                v_back_q   <= cfg_v_back_i;
                v_active_q <= cfg_v_active_i;
                v_front_q  <= cfg_v_front_i;
            end
        end
    end
endmodule

// File: tb/tb_dsi_video_scheduler.sv
// tb_dsi_video_scheduler: directed bench for the DSI video scheduler with an always-ready assembler model.
// Frames use v_sync=2, v_back=1, v_active=2, v_front=1 (6 lines: VSS, HSS, VSE, active, active, HSS).
// A logger records every packet header and payload word; the main sequence compares against tables.
`timescale 1ns/1ps
module tb_dsi_video_scheduler;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [15:0] cfg_h_total_i = 16'd64, cfg_h_active_i = 16'd4, cfg_h_blank_i = 16'd2;
    logic [11:0] cfg_v_sync_i = 12'd2, cfg_v_back_i = 12'd1, cfg_v_active_i = 12'd2, cfg_v_front_i = 12'd1;
    logic [23:0] pix_i = 24'h0;
    logic        pix_valid_i = 1'b1;
    logic        p_dreq_i = 1'b0;
    logic        pix_ack_o, frame_start_o, err_underrun_o, err_late_o;
    logic        p_req_o, p_islong_o, p_last_o;
    logic [5:0]  p_type_o;
    logic [15:0] p_wcount_o, p_command_o;
    logic [23:0] p_payload_o;

    dsi_video_scheduler #(.g_hcnt_bits(16), .g_vcnt_bits(12)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
        .cfg_h_total_i(cfg_h_total_i), .cfg_h_active_i(cfg_h_active_i), .cfg_h_blank_i(cfg_h_blank_i),
        .cfg_v_sync_i(cfg_v_sync_i), .cfg_v_back_i(cfg_v_back_i),
        .cfg_v_active_i(cfg_v_active_i), .cfg_v_front_i(cfg_v_front_i),
        .pix_i(pix_i), .pix_valid_i(pix_valid_i), .pix_ack_o(pix_ack_o),
        .frame_start_o(frame_start_o), .err_underrun_o(err_underrun_o), .err_late_o(err_late_o),
        .p_req_o(p_req_o), .p_islong_o(p_islong_o), .p_type_o(p_type_o), .p_wcount_o(p_wcount_o),
        .p_command_o(p_command_o), .p_payload_o(p_payload_o), .p_last_o(p_last_o), .p_dreq_i(p_dreq_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Packet logger / assembler model: accepts whatever is requested, every cycle
    int          cyc = 0;
    int          ack_cnt = 0, stray_ack = 0, blank_nz = 0, rgb_bad = 0, fs_cnt = 0, cmd_nz = 0;
    logic [5:0]  q_type[$];
    logic        q_last[$];
    logic        q_long[$];
    logic [15:0] q_wc[$];
    int          q_cyc[$];
    logic        in_long = 1'b0;
    int          rem = 0;
    logic [5:0]  cur_type = 6'h0;
    logic [23:0] exp_pay;

    initial forever begin
        @(negedge clk_i);
        cyc++;
        pix_i = 24'(cyc * 32'h00010203 + 32'h00123456);
        p_dreq_i = p_req_o;
        #1;
        if (rst_i) in_long = 1'b0;
        if (frame_start_o) fs_cnt++;
        if (p_command_o != 16'h0) cmd_nz++;
        if (p_req_o && p_dreq_i) begin
            if (!in_long) begin
                if (pix_ack_o) stray_ack++;
                q_type.push_back(p_type_o);
                q_last.push_back(p_last_o);
                q_long.push_back(p_islong_o);
                q_wc.push_back(p_wcount_o);
                q_cyc.push_back(cyc);
                cur_type = p_type_o;
                if (p_islong_o) begin
                    in_long = 1'b1;
                    rem = int'(p_wcount_o) / 3;
                end
            end else begin
                if (cur_type == 6'h19) begin
                    if (p_payload_o != 24'h0) blank_nz++;
                    if (pix_ack_o) stray_ack++;
                end else begin
                    exp_pay = pix_valid_i ? pix_i : 24'h0;
                    if (p_payload_o !== exp_pay) rgb_bad++;
                    if (pix_ack_o) ack_cnt++;
                end
                rem--;
                if (rem <= 0) in_long = 1'b0;
            end
        end else if (pix_ack_o) begin
            stray_ack++;
        end
    end

    // Snapshot of logger state at the start of each scenario
    int b_pkt, b_ack, b_stray, b_blank, b_rgb, b_fs;
    task automatic mark();
        b_pkt = q_type.size(); b_ack = ack_cnt; b_stray = stray_ack;
        b_blank = blank_nz; b_rgb = rgb_bad; b_fs = fs_cnt;
    endtask

    task automatic wait_pkts(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i); #2;
            if (q_type.size() >= b_pkt + n) break;
        end
        check({tag, "_pkts"}, q_type.size() - b_pkt, n);
    endtask

    logic [5:0]  exp_type[16];
    logic        exp_last[16];
    logic [15:0] exp_wc[16];
    int          exp_n;
    int          exp_ls[7];
    int          exp_dt[6];

    task automatic set_exp_a();
        exp_type = '{6'h01, 6'h21, 6'h11, 6'h21, 6'h19, 6'h3E, 6'h21, 6'h19, 6'h3E, 6'h21, 6'h01, 0, 0, 0, 0, 0};
        exp_last = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        exp_wc   = '{0, 0, 0, 0, 6, 12, 0, 6, 12, 0, 0, 0, 0, 0, 0, 0};
        exp_n    = 11;
        exp_ls   = '{0, 1, 2, 3, 6, 9, 10};
    endtask

    task automatic check_log(input string tag);
        for (int i = 0; i < exp_n; i++) begin
            check($sformatf("%s_type%0d", tag, i), q_type[b_pkt+i], exp_type[i]);
            check($sformatf("%s_last%0d", tag, i), q_last[b_pkt+i], exp_last[i]);
            check($sformatf("%s_long%0d", tag, i), q_long[b_pkt+i], exp_wc[i] != 0);
            if (exp_wc[i] != 0) check($sformatf("%s_wc%0d", tag, i), q_wc[b_pkt+i], exp_wc[i]);
        end
    endtask

    task automatic check_lines(input string tag);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_period%0d", tag, i),
                  q_cyc[b_pkt+exp_ls[i+1]] - q_cyc[b_pkt+exp_ls[i]], exp_dt[i]);
    endtask

    task automatic do_reset(input int ht, input int ha, input int hb, input logic pv);
        @(negedge clk_i);
        rst_i = 1'b1; enable_i = 1'b0;
        cfg_h_total_i = 16'(ht); cfg_h_active_i = 16'(ha); cfg_h_blank_i = 16'(hb);
        pix_valid_i = pv;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i); #2;
        mark();
        enable_i = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        #2;
        check("rst_req", p_req_o, 1'b0);
        check("rst_ack", pix_ack_o, 1'b0);
        check("rst_fs", frame_start_o, 1'b0);
        check("rst_underrun", err_underrun_o, 1'b0);
        check("rst_late", err_late_o, 1'b0);
        check("rst_last", p_last_o, 1'b0);
        check("rst_type", p_type_o, 6'h00);
        check("rst_payload", p_payload_o, 24'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #2;
        check("idle_no_enable_req", p_req_o, 1'b0);

        // Nominal frame, h_total=64, h_blank=2, h_active=4
        mark();
        enable_i = 1'b1;
        wait_pkts("nom", 11, 1000);
        set_exp_a();
        exp_dt = '{64, 64, 64, 64, 64, 64};
        check_log("nom");
        check_lines("nom");
        check("nom_acks", ack_cnt - b_ack, 8);
        check("nom_stray_ack", stray_ack - b_stray, 0);
        check("nom_blank_payload", blank_nz - b_blank, 0);
        check("nom_rgb_payload", rgb_bad - b_rgb, 0);
        check("nom_frame_starts", fs_cnt - b_fs, 2);
        check("nom_late", err_late_o, 1'b0);
        check("nom_underrun", err_underrun_o, 1'b0);
        check("nom_command", cmd_nz, 0);

        // Active line needs 9 cycles but h_total=8: two late lines, nothing lost
        do_reset(8, 4, 2, 1'b1);
        wait_pkts("late", 11, 300);
        exp_dt = '{8, 8, 8, 9, 9, 8};
        check_log("late");
        check_lines("late");
        check("late_flag", err_late_o, 1'b1);
        check("late_acks", ack_cnt - b_ack, 8);

        // h_total=9: final word lands exactly on the timer wrap, so the line is on time
        do_reset(9, 4, 2, 1'b1);
        wait_pkts("edge", 11, 300);
        exp_dt = '{9, 9, 9, 9, 9, 9};
        check_lines("edge");
        check("edge_late", err_late_o, 1'b0);

        // Pixel source starved throughout: zero payload, sticky underrun
        do_reset(64, 4, 2, 1'b0);
        wait_pkts("under", 11, 1000);
        check("under_rgb_payload", rgb_bad - b_rgb, 0);
        check("under_acks", ack_cnt - b_ack, 8);
        check("under_flag", err_underrun_o, 1'b1);
        repeat (100) @(negedge clk_i);
        #2;
        check("under_sticky", err_underrun_o, 1'b1);

        // Reset in the middle of RGB payload
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i); #2;
            if (pix_ack_o) break;
        end
        check("mid_rgb_ack_seen", pix_ack_o, 1'b1);
        rst_i = 1'b1;
        @(negedge clk_i); #2;
        check("mid_rst_req", p_req_o, 1'b0);
        check("mid_rst_ack", pix_ack_o, 1'b0);
        check("mid_rst_underrun", err_underrun_o, 1'b0);
        check("mid_rst_late", err_late_o, 1'b0);
        rst_i = 1'b0;
        mark();
        wait_pkts("mid_restart", 1, 50);
        check("mid_restart_type", q_type[b_pkt], 6'h01);
        check("mid_restart_fs", fs_cnt - b_fs, 1);

        // No blanking packet, then drop enable mid-frame
        do_reset(64, 4, 0, 1'b1);
        wait_pkts("nobl", 5, 400);
        exp_type = '{6'h01, 6'h21, 6'h11, 6'h21, 6'h3E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_last = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_wc   = '{0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_n    = 5;
        check_log("nobl");
        enable_i = 1'b0;
        repeat (200) @(negedge clk_i);
        #2;
        check("dis_pkts", q_type.size() - b_pkt, 5);
        check("dis_req", p_req_o, 1'b0);
        check("dis_acks", ack_cnt - b_ack, 4);
        mark();
        enable_i = 1'b1;
        wait_pkts("reen", 1, 50);
        check("reen_type", q_type[b_pkt], 6'h01);
        check("reen_fs", fs_cnt - b_fs, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
